// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled 8N1 receiver with show-ahead FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit (PODD selects odd) and the PARERR flag.
module uart_rx_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             RXD,
  input  logic [DIV_W-1:0] DIV,
  input  logic             RDEN,
  input  logic             CLRERR,
`ifdef UART_RX_PARITY_EN
  input  logic             PODD,
  output logic             PARERR,
`endif
  output logic [7:0]       RDATA,
  output logic             RXVALID,
  output logic             RXFULL,
  output logic             FRAMEERR,
  output logic             OVERRUN,
  output logic             RXINT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t           state_q, state_d;
  logic             s1_q, s2_q, rxs;
  logic [DIV_W-1:0] tcnt_q, tcnt_d, rld_q, lim;
  logic             tick;
  logic [3:0]       sub_q, sub_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             push, fe_set;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             full, pop, wr;
  logic             ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
  logic             pe_set, perr_q;
`endif
  assign rxs    = s2_q;
  // the divisor only follows DIV while idle, so a mid-frame change waits for the next frame
  assign lim    = (state_q == IDLE) ? DIV : rld_q;
  assign tick   = tcnt_q >= lim;
  assign tcnt_d = tick ? '0 : tcnt_q + DIV_W'(1);
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    armed_d = armed_q;
    push    = 1'b0;
    fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_set  = 1'b0;
`endif
    case (state_q)
      IDLE: if (tick) begin
        if (rxs) armed_d = 1'b1;
        else if (armed_q) begin
          state_d = START;
          sub_d   = '0;
        end
      end
      START: if (tick) begin
        sub_d = sub_q + 4'd1;
        if (sub_q == 4'd7) begin
          sub_d   = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: if (tick) begin
        sub_d = sub_q + 4'd1;
        if (sub_q == 4'd15) begin
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        sub_d = sub_q + 4'd1;
        if (sub_q == 4'd15) begin
          pe_set  = ^{shift_q, rxs, PODD};
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        sub_d = sub_q + 4'd1;
        if (sub_q == 4'd15) begin
          push    = rxs;
          fe_set  = !rxs;
          armed_d = rxs;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign pop     = RDEN && (cnt_q != '0);
  assign wr      = push && (!full || pop);
  assign cnt_d   = cnt_q + CW'(wr) - CW'(pop);
  // head register keeps the last byte visible once the FIFO drains
  assign rdata_d = (wr && cnt_q == '0) ? shift_q :
                   !pop ? rdata_q :
                   (cnt_q > CW'(1)) ? mem[rp_q + AW'(1)] :
                   wr ? shift_q : rdata_q;
  always_ff @(posedge CLK) begin
    if (wr) mem[wp_q] <= shift_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      tcnt_q  <= '0;
      rld_q   <= '0;
      state_q <= IDLE;
      sub_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= RXD;
      s2_q    <= s1_q;
      tcnt_q  <= tcnt_d;
      rld_q   <= lim;
      state_q <= state_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      wp_q    <= wr ? wp_q + AW'(1) : wp_q;
      rp_q    <= pop ? rp_q + AW'(1) : rp_q;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ferr_q  <= fe_set || (ferr_q && !CLRERR);
      ovr_q   <= (push && full && !pop) || (ovr_q && !CLRERR);
`ifdef UART_RX_PARITY_EN
      perr_q  <= pe_set || (perr_q && !CLRERR);
`endif
    end
  end
  assign RDATA    = rdata_q;
  assign RXVALID  = cnt_q != '0;
  assign RXFULL   = full;
  assign FRAMEERR = ferr_q;
  assign OVERRUN  = ovr_q;
  assign RXINT    = RXVALID;
`ifdef UART_RX_PARITY_EN
  assign PARERR   = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames at DIV=3 (64 CLK per bit) with hand-computed expectations.
module tb_uart_rx_core;
  logic        CLK = 1'b0;
  logic        RESETn, RXD, RDEN, CLRERR;
  logic [15:0] DIV;
  logic [7:0]  RDATA;
  logic        RXVALID, RXFULL, FRAMEERR, OVERRUN, RXINT;
  int          checks = 0;
  int          errors = 0;
`ifdef UART_RX_PARITY_EN
  logic        PODD, PARERR;
  logic        bad_par = 1'b0;
`endif
  uart_rx_core #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .CLK(CLK), .RESETn(RESETn), .RXD(RXD), .DIV(DIV), .RDEN(RDEN), .CLRERR(CLRERR),
`ifdef UART_RX_PARITY_EN
    .PODD(PODD), .PARERR(PARERR),
`endif
    .RDATA(RDATA), .RXVALID(RXVALID), .RXFULL(RXFULL),
    .FRAMEERR(FRAMEERR), .OVERRUN(OVERRUN), .RXINT(RXINT)
  );
  always #5 CLK = ~CLK;
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  // start bit, data bits LSB first and (if built in) the parity bit; returns as the stop bit begins
  task automatic send_bits(input logic [7:0] d);
    RXD = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      cyc(64);
    end
`ifdef UART_RX_PARITY_EN
    RXD = ^d ^ PODD ^ bad_par;
    cyc(64);
`endif
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    send_bits(d);
    RXD = stop;
    cyc(64);
    RXD = 1'b1;
    cyc(16);
  endtask
  task automatic pop;
    RDEN = 1'b1;
    cyc(1);
    RDEN = 1'b0;
  endtask
  task automatic clrerr;
    CLRERR = 1'b1;
    cyc(1);
    CLRERR = 1'b0;
  endtask
  initial begin
    RESETn = 1'b0;
    RXD    = 1'b1;
    DIV    = 16'd3;
    RDEN   = 1'b0;
    CLRERR = 1'b0;
`ifdef UART_RX_PARITY_EN
    PODD   = 1'b0;
`endif
    cyc(2);
    chk("rst_rdata", RDATA, 8'h00);
    chk("rst_rxvalid", RXVALID, 1'b0);
    chk("rst_rxfull", RXFULL, 1'b0);
    chk("rst_frameerr", FRAMEERR, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    chk("rst_rxint", RXINT, 1'b0);
    RESETn = 1'b1;
    cyc(16);
    // stop sample lands 36 CLK into the stop bit
    send_bits(8'h48);
    RXD = 1'b1;
    cyc(24);
    chk("lat_early_rxvalid", RXVALID, 1'b0);
    cyc(20);
    chk("lat_rxvalid", RXVALID, 1'b1);
    chk("lat_rdata", RDATA, 8'h48);
    chk("lat_rxint", RXINT, 1'b1);
    cyc(36);
    pop();
    chk("pop_rxvalid", RXVALID, 1'b0);
    chk("pop_rxint", RXINT, 1'b0);
    RXD = 1'b0;
    cyc(12);
    RXD = 1'b1;
    cyc(64);
    chk("glitch_rxvalid", RXVALID, 1'b0);
    chk("glitch_frameerr", FRAMEERR, 1'b0);
    chk("glitch_overrun", OVERRUN, 1'b0);
    send(8'h55, 1'b0);
    chk("fe_frameerr", FRAMEERR, 1'b1);
    chk("fe_rxvalid", RXVALID, 1'b0);
    clrerr();
    chk("fe_clear", FRAMEERR, 1'b0);
    send(8'h41, 1'b1);
    chk("after_fe_rxvalid", RXVALID, 1'b1);
    chk("after_fe_rdata", RDATA, 8'h41);
    pop();
    chk("after_fe_empty", RXVALID, 1'b0);
    send(8'h68, 1'b1);
    send(8'h65, 1'b1);
    send(8'h6C, 1'b1);
    send(8'h6C, 1'b1);
    send(8'h6F, 1'b1);
    chk("hello_rxfull", RXFULL, 1'b1);
    chk("hello_overrun", OVERRUN, 1'b1);
    chk("hello_rd0", RDATA, 8'h68);
    pop();
    chk("hello_rd1", RDATA, 8'h65);
    pop();
    chk("hello_rd2", RDATA, 8'h6C);
    pop();
    chk("hello_rd3", RDATA, 8'h6C);
    pop();
    chk("hello_empty", RXVALID, 1'b0);
    chk("hello_not_full", RXFULL, 1'b0);
    chk("hello_hold", RDATA, 8'h6C);
    clrerr();
    chk("hello_ovr_clear", OVERRUN, 1'b0);
    // fresh reset fixes the tick phase so the push edge is exactly 36 CLK into the stop bit
    RESETn = 1'b0;
    cyc(2);
    RESETn = 1'b1;
    cyc(16);
    send(8'h68, 1'b1);
    send(8'h65, 1'b1);
    send(8'h6C, 1'b1);
    send(8'h6C, 1'b1);
    chk("ovl_full", RXFULL, 1'b1);
    send_bits(8'h6F);
    RXD = 1'b1;
    cyc(35);
    RDEN = 1'b1;
    cyc(1);
    RDEN = 1'b0;
    chk("ovl_overrun", OVERRUN, 1'b0);
    chk("ovl_still_full", RXFULL, 1'b1);
    chk("ovl_head", RDATA, 8'h65);
    cyc(44);
    pop();
    chk("ovl_rd1", RDATA, 8'h6C);
    pop();
    chk("ovl_rd2", RDATA, 8'h6C);
    pop();
    chk("ovl_rd3", RDATA, 8'h6F);
    pop();
    chk("ovl_empty", RXVALID, 1'b0);
    RXD = 1'b0;
    cyc(64);
    RXD = 1'b0;
    cyc(64);
    RXD = 1'b1;
    cyc(64);
    RXD = 1'b0;
    cyc(64);
    RESETn = 1'b0;
    cyc(1);
    RESETn = 1'b1;
    RXD = 1'b1;
    cyc(160);
    chk("midrst_rxvalid", RXVALID, 1'b0);
    chk("midrst_frameerr", FRAMEERR, 1'b0);
    send(8'h33, 1'b1);
    chk("midrst_rx_valid", RXVALID, 1'b1);
    chk("midrst_rdata", RDATA, 8'h33);
    chk("midrst_noflag_fe", FRAMEERR, 1'b0);
    chk("midrst_noflag_ovr", OVERRUN, 1'b0);
    pop();
    chk("midrst_empty", RXVALID, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk("par_idle", PARERR, 1'b0);
    bad_par = 1'b1;
    send(8'h07, 1'b1);
    bad_par = 1'b0;
    chk("par_err", PARERR, 1'b1);
    chk("par_rdata", RDATA, 8'h07);
    chk("par_rxvalid", RXVALID, 1'b1);
    clrerr();
    chk("par_clear", PARERR, 1'b0);
    pop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
